// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU.
// Optional macro ALU_DIVZERO_TRAP_EN: trap DIV/MOD by zero without using the ALU.
module alu_arbiter #(
    parameter int unsigned MULTI_LAT = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_0,
    input  logic        Req_1,
    input  logic [4:0]  Op_0,
    input  logic [4:0]  Op_1,
    input  logic [31:0] A_0,
    input  logic [31:0] A_1,
    input  logic [31:0] B_0,
    input  logic [31:0] B_1,
    output logic        Ack_0,
    output logic        Ack_1,
    output logic [31:0] Res_0,
    output logic [31:0] Res_1,
    output logic        True_0,
    output logic        True_1,
    output logic        Err_0,
    output logic        Err_1,
    output logic [4:0]  ALU_Op,
    output logic [31:0] ALU_Data_1,
    output logic [31:0] ALU_Data_2,
    input  logic [31:0] ALU_Result,
    input  logic        ALU_True,
    output logic        Busy,
    output logic        Grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] OP_NOP = 5'd17;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [3:0] LAT_M1 = 4'(MULTI_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic        last;
    logic [3:0]  cnt;
    logic [4:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        gnt_v;
    logic        gnt_idx;
    logic [4:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_multi;
    logic        trap;
    logic        done;

    // Ties go to the requester that was not served last.
    always_comb begin
        gnt_v   = (state == IDLE) && (Req_0 || Req_1);
        gnt_idx = (Req_0 && Req_1) ? ~last : Req_1;
        sel_op  = gnt_idx ? Op_1 : Op_0;
        sel_a   = gnt_idx ? A_1 : A_0;
        sel_b   = gnt_idx ? B_1 : B_0;
        sel_multi = (sel_op == OP_MUL) || (sel_op == OP_DIV) ||
                    (sel_op == OP_MOD);
        done    = (state == EXEC) && (cnt == 4'd0);
    end

`ifdef ALU_DIVZERO_TRAP_EN
    always_comb begin
        trap = gnt_v && ((sel_op == OP_DIV) || (sel_op == OP_MOD)) &&
               (sel_b == 32'd0);
    end
`else
    always_comb begin
        trap = 1'b0;
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (gnt_v) begin
                    state_nx = trap ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            last  <= 1'b1;
            Grant <= 1'b0;
            cnt   <= 4'd0;
            op_q  <= OP_NOP;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else begin
            if (gnt_v) begin
                last  <= gnt_idx;
                Grant <= gnt_idx;
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                cnt   <= sel_multi ? LAT_M1 : 4'd0;
            end else if ((state == EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Res_0  <= 32'd0;
            Res_1  <= 32'd0;
            True_0 <= 1'b0;
            True_1 <= 1'b0;
        end else if (done) begin
            if (Grant) begin
                Res_1  <= ALU_Result;
                True_1 <= ALU_True;
            end else begin
                Res_0  <= ALU_Result;
                True_0 <= ALU_True;
            end
        end else if (trap) begin
            if (gnt_idx) begin
                Res_1  <= 32'd0;
                True_1 <= 1'b0;
            end else begin
                Res_0  <= 32'd0;
                True_0 <= 1'b0;
            end
        end
    end

`ifdef ALU_DIVZERO_TRAP_EN
    // Err is sticky per requester until its next normal completion.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Err_0 <= 1'b0;
            Err_1 <= 1'b0;
        end else if (done) begin
            if (Grant) begin
                Err_1 <= 1'b0;
            end else begin
                Err_0 <= 1'b0;
            end
        end else if (trap) begin
            if (gnt_idx) begin
                Err_1 <= 1'b1;
            end else begin
                Err_0 <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        Err_0 = 1'b0;
        Err_1 = 1'b0;
    end
`endif

    always_comb begin
        Busy       = (state != IDLE);
        Ack_0      = (state == RESP) && !Grant;
        Ack_1      = (state == RESP) && Grant;
        ALU_Op     = OP_NOP;
        ALU_Data_1 = 32'd0;
        ALU_Data_2 = 32'd0;
        if (state == EXEC) begin
            ALU_Op     = op_q;
            ALU_Data_1 = a_q;
            ALU_Data_2 = b_q;
        end
    end

endmodule
